// File: rtl/dbg_axi_tx_pkg.sv
// Shared definitions for the debug memory-access CDC bridge: FSM states,
// transfer size encodings and the request bundle carried across the crossing.
package dbg_axi_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DRAIN  = 2'd3
  } dbg_state_e;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;

  localparam int PROT_W = 7;

  typedef struct packed {
    logic              sector;
    logic [31:0]       addr;
    logic              write;
    logic [31:0]       wdata;
    logic [2:0]        size;
    logic [PROT_W-1:0] prot;
    logic              secen;
  } dbg_req_t;

  // Anything wider than a word cannot be issued on the 32-bit AXI side.
  function automatic logic size_ok(input logic [2:0] size);
    return size <= SIZE_W;
  endfunction

endpackage

// File: rtl/dbg_axi_tx_if.sv
// Request/response link between the tx (debug-AP) and rx (AXI) halves of the
// bridge; master is the tx side, slave is the rx side.
interface dbg_axi_tx_if;
  import dbg_axi_tx_pkg::*;

  logic              tx_tog;
  logic              tx_mem_sector;
  logic [31:0]       tx_mem_addr;
  logic              tx_mem_write;
  logic [31:0]       tx_mem_wdata;
  logic [2:0]        tx_mem_size;
  logic [PROT_W-1:0] tx_mem_prot;
  logic              tx_mem_secen;
  logic              rx_tog;
  logic [31:0]       rx_mem_rdata;
  logic              rx_mem_slverr;

  modport master (
    output tx_tog, tx_mem_sector, tx_mem_addr, tx_mem_write,
           tx_mem_wdata, tx_mem_size, tx_mem_prot, tx_mem_secen,
    input  rx_tog, rx_mem_rdata, rx_mem_slverr
  );

  modport slave (
    input  tx_tog, tx_mem_sector, tx_mem_addr, tx_mem_write,
           tx_mem_wdata, tx_mem_size, tx_mem_prot, tx_mem_secen,
    output rx_tog, rx_mem_rdata, rx_mem_slverr
  );

endinterface

// File: rtl/dbg_axi_tx_tog_sync.sv
// Toggle synchronizer with registered edge detect; edges seen while the
// post-reset ignore counter is non-zero are discarded.
module dbg_tog_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int IGNORE_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic tog_in,
  output logic tog_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic [3:0]             ignore_cnt;

  // The ignore window swallows toggles left over from a transfer cut short by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      sync_prev  <= 1'b0;
      ignore_cnt <= 4'(IGNORE_CYCLES);
      tog_edge   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], tog_in};
      sync_prev <= sync_q[SYNC_STAGES-1];
      if (ignore_cnt != 4'd0)
        ignore_cnt <= ignore_cnt - 4'd1;
      tog_edge  <= (sync_q[SYNC_STAGES-1] ^ sync_prev) && (ignore_cnt == 4'd0);
    end
  end

endmodule

// File: rtl/dbg_axi_tx.sv
// Transmit half of the debug memory-access CDC bridge (debug-AP clock domain).
// Define DBG_AXI_TX_TIMEOUT_EN to add the WAIT timeout and DRAIN state.
module dbg_axi_tx
  import dbg_axi_tx_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int IGNORE_CYCLES  = 15,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              tx_clk,
  input  logic              tx_rst,
  input  logic              mem_req,
  input  logic              mem_sector,
  input  logic [31:0]       mem_addr,
  input  logic              mem_write,
  input  logic [31:0]       mem_wdata,
  input  logic [2:0]        mem_size,
  input  logic [PROT_W-1:0] mem_prot,
  input  logic              mem_secen,
  output logic              mem_busy,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              mem_slverr,
  output logic              mem_timeout,
  dbg_axi_tx_if.master      link
);

  dbg_state_e  state_q, state_nxt;
  dbg_req_t    req_q, req_nxt;
  logic        tog_q, tog_nxt;
  logic        done_q, done_nxt;
  logic [31:0] rdata_q, rdata_nxt;
  logic        slverr_q, slverr_nxt;
  logic        rx_edge;

`ifdef DBG_AXI_TX_TIMEOUT_EN
  logic [11:0] timer_q, timer_nxt;
  logic        timeout_q, timeout_nxt;
`endif

  dbg_tog_sync #(
    .SYNC_STAGES   (SYNC_STAGES),
    .IGNORE_CYCLES (IGNORE_CYCLES)
  ) u_rx_sync (
    .clk      (tx_clk),
    .rst      (tx_rst),
    .tog_in   (link.rx_tog),
    .tog_edge (rx_edge)
  );

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state_q  <= IDLE;
      req_q    <= '0;
      tog_q    <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
`ifdef DBG_AXI_TX_TIMEOUT_EN
      timer_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_nxt;
      req_q    <= req_nxt;
      tog_q    <= tog_nxt;
      done_q   <= done_nxt;
      rdata_q  <= rdata_nxt;
      slverr_q <= slverr_nxt;
`ifdef DBG_AXI_TX_TIMEOUT_EN
      timer_q   <= timer_nxt;
      timeout_q <= timeout_nxt;
`endif
    end
  end

  // Fields are registered in IDLE and the toggle flips one cycle later in
  // LAUNCH, so the rx side never samples a field that is still settling.
  always_comb begin
    state_nxt  = state_q;
    req_nxt    = req_q;
    tog_nxt    = tog_q;
    done_nxt   = 1'b0;
    rdata_nxt  = rdata_q;
    slverr_nxt = slverr_q;
`ifdef DBG_AXI_TX_TIMEOUT_EN
    timer_nxt   = timer_q;
    timeout_nxt = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          if (!size_ok(mem_size)) begin
            done_nxt   = 1'b1;
            slverr_nxt = 1'b1;
            rdata_nxt  = '0;
          end else begin
            req_nxt   = '{sector: mem_sector, addr: mem_addr, write: mem_write,
                          wdata: mem_wdata, size: mem_size, prot: mem_prot,
                          secen: mem_secen};
            state_nxt = LAUNCH;
`ifdef DBG_AXI_TX_TIMEOUT_EN
            timeout_nxt = 1'b0;
`endif
          end
        end
      end
      LAUNCH: begin
        tog_nxt   = ~tog_q;
        state_nxt = WAIT;
`ifdef DBG_AXI_TX_TIMEOUT_EN
        timer_nxt = '0;
`endif
      end
      WAIT: begin
        if (rx_edge) begin
          rdata_nxt  = link.rx_mem_rdata;
          slverr_nxt = link.rx_mem_slverr;
          done_nxt   = 1'b1;
          state_nxt  = IDLE;
        end
`ifdef DBG_AXI_TX_TIMEOUT_EN
        else if (timer_q == 12'(TIMEOUT_CYCLES - 1)) begin
          rdata_nxt   = '0;
          slverr_nxt  = 1'b1;
          timeout_nxt = 1'b1;
          done_nxt    = 1'b1;
          state_nxt   = DRAIN;
        end else begin
          timer_nxt = timer_q + 12'd1;
        end
`endif
      end
`ifdef DBG_AXI_TX_TIMEOUT_EN
      // The abandoned response must still be consumed before a new launch.
      DRAIN: begin
        if (rx_edge)
          state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_busy   = (state_q != IDLE);
  assign mem_done   = done_q;
  assign mem_rdata  = rdata_q;
  assign mem_slverr = slverr_q;
`ifdef DBG_AXI_TX_TIMEOUT_EN
  assign mem_timeout = timeout_q;
`else
  assign mem_timeout = 1'b0;
`endif

  assign link.tx_tog        = tog_q;
  assign link.tx_mem_sector = req_q.sector;
  assign link.tx_mem_addr   = req_q.addr;
  assign link.tx_mem_write  = req_q.write;
  assign link.tx_mem_wdata  = req_q.wdata;
  assign link.tx_mem_size   = req_q.size;
  assign link.tx_mem_prot   = req_q.prot;
  assign link.tx_mem_secen  = req_q.secen;

endmodule

// File: tb/tb_dbg_axi_tx.sv
// Directed bench for dbg_axi_tx; the rx side is played by hand-driven toggles.
// Define DBG_AXI_TX_TIMEOUT_EN to also exercise the timeout/drain path.
module tb_dbg_axi_tx;
  import dbg_axi_tx_pkg::*;

`ifdef DBG_AXI_TX_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 4096;
`endif

  logic        tx_clk = 1'b0;
  logic        tx_rst;
  logic        mem_req, mem_sector, mem_write, mem_secen;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_size;
  logic [6:0]  mem_prot;
  logic        mem_busy, mem_done, mem_slverr, mem_timeout;
  logic [31:0] mem_rdata;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt     = 0;
  int tog_cnt      = 0;
  logic tog_prev   = 1'b0;
  logic exp_tog    = 1'b0;
  int lat, done0, tog0;

  dbg_axi_tx_if link ();

  dbg_axi_tx #(
    .SYNC_STAGES    (2),
    .IGNORE_CYCLES  (15),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .tx_clk      (tx_clk),
    .tx_rst      (tx_rst),
    .mem_req     (mem_req),
    .mem_sector  (mem_sector),
    .mem_addr    (mem_addr),
    .mem_write   (mem_write),
    .mem_wdata   (mem_wdata),
    .mem_size    (mem_size),
    .mem_prot    (mem_prot),
    .mem_secen   (mem_secen),
    .mem_busy    (mem_busy),
    .mem_done    (mem_done),
    .mem_rdata   (mem_rdata),
    .mem_slverr  (mem_slverr),
    .mem_timeout (mem_timeout),
    .link        (link)
  );

  always #5 tx_clk = ~tx_clk;

  always @(posedge tx_clk) begin
    if (mem_done === 1'b1) done_cnt++;
    if (link.tx_tog !== tog_prev) tog_cnt++;
    tog_prev = link.tx_tog;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle request at the current negedge; returns one negedge later.
  task automatic applyStimulus(input logic sector, input logic [31:0] addr, input logic write,
                               input logic [31:0] wdata, input logic [2:0] size,
                               input logic [6:0] prot, input logic secen);
    mem_req    = 1'b1;
    mem_sector = sector;
    mem_addr   = addr;
    mem_write  = write;
    mem_wdata  = wdata;
    mem_size   = size;
    mem_prot   = prot;
    mem_secen  = secen;
    @(negedge tx_clk);
    mem_req    = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rdata, input logic slverr);
    link.rx_mem_rdata  = rdata;
    link.rx_mem_slverr = slverr;
    link.rx_tog        = ~link.rx_tog;
  endtask

  task automatic waitDone(output int cycles);
    int i;
    cycles = 0;
    i = 0;
    while (cycles == 0 && i < 40) begin
      @(negedge tx_clk);
      i++;
      if (mem_done === 1'b1) cycles = i;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge tx_clk);
  endtask

  initial begin
    tx_rst = 1'b1;
    mem_req = 1'b0; mem_sector = 1'b0; mem_addr = '0; mem_write = 1'b0;
    mem_wdata = '0; mem_size = SIZE_W; mem_prot = '0; mem_secen = 1'b0;
    link.rx_tog = 1'b1;
    link.rx_mem_rdata = '0;
    link.rx_mem_slverr = 1'b0;

    // Reset with rx_tog already high: its synchronized edge lands in the ignore window
    idle(3);
    checkOutput("rst_tx_tog", 32'(link.tx_tog), 32'd0);
    checkOutput("rst_busy", 32'(mem_busy), 32'd0);
    checkOutput("rst_rdata", mem_rdata, 32'h0);
    tx_rst = 1'b0;
    done0 = done_cnt;
    idle(20);
    checkOutput("post_rst_done_cnt", 32'(done_cnt - done0), 32'd0);
    checkOutput("post_rst_tx_tog", 32'(link.tx_tog), 32'd0);
    checkOutput("post_rst_busy", 32'(mem_busy), 32'd0);

    // Word read
    applyStimulus(1'b0, 32'h0000_1000, 1'b0, 32'h0, SIZE_W, 7'h02, 1'b0);
    checkOutput("rd_tog_launch", 32'(link.tx_tog), 32'd0);
    checkOutput("rd_busy", 32'(mem_busy), 32'd1);
    checkOutput("rd_addr", link.tx_mem_addr, 32'h0000_1000);
    idle(1);
    exp_tog = ~exp_tog;
    checkOutput("rd_tog_flip", 32'(link.tx_tog), 32'(exp_tog));
    respond(32'hDEAD_BEEF, 1'b0);
    waitDone(lat);
    checkOutput("rd_latency", 32'(lat), 32'd4);
    checkOutput("rd_rdata", mem_rdata, 32'hDEAD_BEEF);
    checkOutput("rd_slverr", 32'(mem_slverr), 32'd0);
    checkOutput("rd_busy_done", 32'(mem_busy), 32'd0);
    idle(1);
    checkOutput("rd_done_pulse", 32'(mem_done), 32'd0);

    // Half-word write with error response; AP inputs change after the request
    applyStimulus(1'b0, 32'h0000_0003, 1'b1, 32'h0000_ABCD, SIZE_H, 7'h55, 1'b1);
    mem_addr = 32'hFFFF_FFFF; mem_wdata = 32'h1234_5678; mem_size = SIZE_B;
    mem_prot = 7'h00; mem_secen = 1'b0; mem_write = 1'b0;
    idle(2);
    exp_tog = ~exp_tog;
    checkOutput("wr_tog_flip", 32'(link.tx_tog), 32'(exp_tog));
    respond(32'h0BAD_F00D, 1'b1);
    idle(2);
    checkOutput("wr_addr_held", link.tx_mem_addr, 32'h0000_0003);
    checkOutput("wr_wdata_held", link.tx_mem_wdata, 32'h0000_ABCD);
    checkOutput("wr_size_held", 32'(link.tx_mem_size), 32'd1);
    checkOutput("wr_write_held", 32'(link.tx_mem_write), 32'd1);
    checkOutput("wr_prot_held", 32'(link.tx_mem_prot), 32'h55);
    checkOutput("wr_secen_held", 32'(link.tx_mem_secen), 32'd1);
    waitDone(lat);
    checkOutput("wr_latency", 32'(lat), 32'd2);
    checkOutput("wr_slverr", 32'(mem_slverr), 32'd1);
    checkOutput("wr_rdata", mem_rdata, 32'h0BAD_F00D);
    idle(2);

    // Illegal size: immediate error completion, no toggle
    tog0 = tog_cnt;
    applyStimulus(1'b0, 32'h0000_0010, 1'b0, 32'h0, 3'd3, 7'h0, 1'b0);
    checkOutput("bad_done", 32'(mem_done), 32'd1);
    checkOutput("bad_slverr", 32'(mem_slverr), 32'd1);
    checkOutput("bad_rdata", mem_rdata, 32'h0);
    checkOutput("bad_busy", 32'(mem_busy), 32'd0);
    idle(3);
    checkOutput("bad_tog_edges", 32'(tog_cnt - tog0), 32'd0);
    checkOutput("bad_tx_tog", 32'(link.tx_tog), 32'(exp_tog));

    // Second request during WAIT ignored; back-to-back request on mem_done accepted
    done0 = done_cnt;
    tog0  = tog_cnt;
    applyStimulus(1'b1, 32'h0000_2000, 1'b0, 32'h0, SIZE_W, 7'h01, 1'b0);
    idle(1);
    exp_tog = ~exp_tog;
    applyStimulus(1'b0, 32'h0000_3000, 1'b0, 32'h0, SIZE_W, 7'h01, 1'b0);
    checkOutput("ign_addr_held", link.tx_mem_addr, 32'h0000_2000);
    checkOutput("ign_sector_held", 32'(link.tx_mem_sector), 32'd1);
    checkOutput("ign_busy", 32'(mem_busy), 32'd1);
    respond(32'h1111_2222, 1'b0);
    waitDone(lat);
    checkOutput("ign_latency", 32'(lat), 32'd4);
    checkOutput("ign_rdata", mem_rdata, 32'h1111_2222);
    applyStimulus(1'b0, 32'h0000_4000, 1'b0, 32'h0, SIZE_W, 7'h00, 1'b0);
    checkOutput("b2b_busy", 32'(mem_busy), 32'd1);
    checkOutput("b2b_addr", link.tx_mem_addr, 32'h0000_4000);
    checkOutput("ign_done_count", 32'(done_cnt - done0), 32'd1);
    checkOutput("ign_tog_edges", 32'(tog_cnt - tog0), 32'd1);
    idle(1);
    exp_tog = ~exp_tog;
    checkOutput("b2b_tog_flip", 32'(link.tx_tog), 32'(exp_tog));
    respond(32'h4444_0000, 1'b0);
    waitDone(lat);
    checkOutput("b2b_latency", 32'(lat), 32'd4);
    checkOutput("b2b_rdata", mem_rdata, 32'h4444_0000);

    // Stale response edge while IDLE is dropped
    idle(2);
    done0 = done_cnt;
    respond(32'h5555_5555, 1'b1);
    idle(10);
    checkOutput("stale_done_count", 32'(done_cnt - done0), 32'd0);
    checkOutput("stale_rdata", mem_rdata, 32'h4444_0000);

    // Reset mid-transfer; the late response falls in the ignore window
    applyStimulus(1'b0, 32'h0000_5000, 1'b0, 32'h0, SIZE_W, 7'h00, 1'b0);
    idle(1);
    tx_rst = 1'b1;
    idle(2);
    checkOutput("midrst_tx_tog", 32'(link.tx_tog), 32'd0);
    checkOutput("midrst_busy", 32'(mem_busy), 32'd0);
    checkOutput("midrst_addr", link.tx_mem_addr, 32'h0);
    tx_rst = 1'b0;
    exp_tog = 1'b0;
    done0 = done_cnt;
    respond(32'h6666_6666, 1'b0);
    idle(20);
    checkOutput("midrst_done_count", 32'(done_cnt - done0), 32'd0);
    checkOutput("midrst_busy_after", 32'(mem_busy), 32'd0);

`ifdef DBG_AXI_TX_TIMEOUT_EN
    // No response: abort after TO_CYC WAIT cycles, then drain the late edge
    applyStimulus(1'b0, 32'h0000_7000, 1'b0, 32'h0, SIZE_W, 7'h00, 1'b0);
    exp_tog = ~exp_tog;
    waitDone(lat);
    checkOutput("to_latency", 32'(lat), 32'(TO_CYC + 1));
    checkOutput("to_slverr", 32'(mem_slverr), 32'd1);
    checkOutput("to_timeout", 32'(mem_timeout), 32'd1);
    checkOutput("to_rdata", mem_rdata, 32'h0);
    checkOutput("to_busy_drain", 32'(mem_busy), 32'd1);
    idle(5);
    done0 = done_cnt;
    respond(32'h7777_7777, 1'b0);
    idle(8);
    checkOutput("drain_done_count", 32'(done_cnt - done0), 32'd0);
    checkOutput("drain_busy", 32'(mem_busy), 32'd0);
    checkOutput("drain_timeout_sticky", 32'(mem_timeout), 32'd1);
    applyStimulus(1'b0, 32'h0000_8000, 1'b0, 32'h0, SIZE_W, 7'h00, 1'b0);
    checkOutput("to_clear", 32'(mem_timeout), 32'd0);
    idle(1);
    exp_tog = ~exp_tog;
    checkOutput("to_next_tog", 32'(link.tx_tog), 32'(exp_tog));
    respond(32'h8888_8888, 1'b0);
    waitDone(lat);
    checkOutput("to_next_latency", 32'(lat), 32'd4);
`else
    checkOutput("no_timeout", 32'(mem_timeout), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dbg_axi_tx.md
Name: dbg_axi_tx

Overview:
Transmit-side (debug-AP clock domain) half of the debug memory-access CDC bridge; directly upstream of the AXI receive stage that issues the AXI transactions.
- Accepts one memory request from the debug AP register file.
- Holds the request fields stable and signals the rx domain with a toggle (`tx_tog`).
- Waits for the returning `rx_tog` edge, then captures read data / error and reports completion to the AP.

Parameters:
- SYNC_STAGES, 2: number of flops synchronizing `rx_tog` into `tx_clk` (min 2).
- IGNORE_CYCLES, 15: cycles after reset during which synchronized `rx_tog` edges are discarded (4-bit counter).
- TIMEOUT_CYCLES, 4096: cycles in WAIT before abort; used only with the optional feature.

Ports:
- tx_clk  in  1  transmit-domain clock.
- tx_rst  in  1  asynchronous active-high reset.
- mem_req  in  1  single-cycle request pulse from AP; sampled only in IDLE.
- mem_sector  in  1  request a 64-byte sector read.
- mem_addr  in  32  byte address.
- mem_write  in  1  1=write, 0=read.
- mem_wdata  in  32  write data, LSB-aligned.
- mem_size  in  3  0=byte, 1=half, 2=word.
- mem_prot  in  7  protection bits.
- mem_secen  in  1  secure access enable.
- mem_busy  out  1  request outstanding (state != IDLE).
- mem_done  out  1  one-cycle completion pulse.
- mem_rdata  out  32  captured read data.
- mem_slverr  out  1  captured error.
- mem_timeout  out  1  sticky; last completion was a timeout (optional feature only, else tied 0).
- tx_tog  out  1  request toggle to rx domain.
- tx_mem_sector, tx_mem_addr[32], tx_mem_write, tx_mem_wdata[32], tx_mem_size[3], tx_mem_prot[7], tx_mem_secen  out  held request fields.
- rx_tog  in  1  response toggle from rx domain (async).
- rx_mem_rdata  in  32  response data (async, stable once `rx_tog` edge is seen).
- rx_mem_slverr  in  1  response error (async, stable once `rx_tog` edge is seen).

Behaviour:
- Reset values: all outputs 0, state IDLE, synchronizer flops 0, ignore counter = IGNORE_CYCLES.
- Ignore counter: decrements to 0. `rx_edge` = (sync_last ^ sync_prev) & (ignore_cnt==0).
- IDLE:
  - `mem_req` with `mem_size`>2 → no toggle; next cycle `mem_done`=1, `mem_slverr`=1, `mem_rdata`=0; stay IDLE.
  - `mem_req` with valid size → register all `tx_mem_*` fields; go to LAUNCH.
- LAUNCH (1 cycle): invert `tx_tog`; go to WAIT. Fields are therefore stable at least one cycle before the toggle edge.
- WAIT: `tx_mem_*` held constant. On `rx_edge`: capture `rx_mem_rdata` and `rx_mem_slverr` into `mem_rdata`/`mem_slverr`, pulse `mem_done` next cycle, go to IDLE.
- Latency: `mem_done` asserts SYNC_STAGES+2 cycles after the `rx_tog` change reaches the first sync flop.
- Sector reads: single completion only (sector data goes directly to the AP buffer in the rx domain); `mem_rdata` = first beat as reported.
- `mem_req` while busy: ignored, no queueing.
- `rx_edge` while IDLE or LAUNCH: dropped (stale response), no `mem_done`.
- `tx_rst` mid-transfer: everything returns to reset values; the late `rx_tog` edge falls in the ignore window or arrives in IDLE and is dropped.
- `mem_done` and a new `mem_req` in the same cycle: the request is accepted (state is already IDLE).

Optional Feature:
- Macro DBG_AXI_TX_TIMEOUT_EN.
- With it:
  - A 12-bit counter runs in WAIT.
  - At TIMEOUT_CYCLES: `mem_done`=1, `mem_slverr`=1, `mem_timeout`=1, `mem_rdata`=0; go to DRAIN.
  - DRAIN keeps `mem_busy`=1 and waits for the late `rx_edge`, then IDLE with no `mem_done`.
  - `mem_timeout` clears on the next accepted `mem_req`.
- Without it: no counter, no DRAIN state, `mem_timeout`=0, and WAIT is unbounded.

Decomposition:
- Shared dbg package: state enum (IDLE, LAUNCH, WAIT, DRAIN), size encodings (SIZE_B/H/W), a PROT_W=7 constant.
- One sub-module, `dbg_tog_sync`: an SYNC_STAGES-deep synchronizer plus edge detect and ignore counter, reusable by the rx side.

Test Plan:
- Reset released, `rx_tog` held 1 from cycle 0 → no `mem_done`, `tx_tog`=0, `mem_busy`=0.
- Word read addr 0x1000 → `tx_tog` 0→1 one cycle after the request; model returns edge with rdata 0xDEADBEEF, slverr 0 → `mem_done` 1 cycle, `mem_rdata`=0xDEADBEEF, `mem_busy` low same cycle.
- Write size=1, addr 0x3, wdata 0xABCD → `tx_mem_*` stable throughout WAIT; response slverr=1 → `mem_slverr`=1.
- `mem_req` with size=3 → no `tx_tog` change, `mem_done`=1, `mem_slverr`=1.
- Second `mem_req` during WAIT → ignored; exactly one `tx_tog` edge and one `mem_done`.
- Macro on, TIMEOUT_CYCLES=16, no response → `mem_done` at cycle 16 with slverr=1, timeout=1; late edge at cycle 40 → no `mem_done`, `mem_busy` falls.
